// File: rtl/slice_scheduler.sv
// slice_scheduler
// Frame-level controller for the ProRes slice pipeline. A frame command
// (slice count, blocks per slice) is accepted in IDLE; every slice is then
// issued with a slice_start pulse, walked through the DCT, DC-VLC and AC-VLC
// phases, and offered to the bitstream packer with a valid/ready handshake.
//
// Ports:
//   clock            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   frame_start      one-cycle frame command pulse, sampled only in IDLE
//   slices_per_frame slice count, latched on an accepted frame_start
//   block_num_in     blocks per slice, latched on an accepted frame_start
//   abort            synchronous abort back to IDLE
//   pack_ready       packer can accept a slice
//   block_num        latched block count, driven to the per-slice sequencer
//   slice_start      one-cycle pulse per slice
//   slice_index      0-based index of the current slice
//   dct_active       DCT phase in progress
//   dc_active        DC-VLC phase in progress
//   ac_active        AC-VLC phase in progress
//   slice_valid      finished slice offered to the packer
//   frame_done       one-cycle pulse after the last slice handshake
//   busy             controller is not IDLE
//   cfg_error        one-cycle pulse on a rejected frame command
module slice_scheduler #(
  parameter int unsigned DCT_TIME    = 12,
  parameter int unsigned DC_VLC_TIME = 44,
  parameter int unsigned AC_TAIL     = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [15:0] slices_per_frame,
  input  logic [31:0] block_num_in,
  input  logic        abort,
  input  logic        pack_ready,
  output logic [31:0] block_num,
  output logic        slice_start,
  output logic [15:0] slice_index,
  output logic        dct_active,
  output logic        dc_active,
  output logic        ac_active,
  output logic        slice_valid,
  output logic        frame_done,
  output logic        busy,
  output logic        cfg_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DCT,
    S_DCVLC,
    S_ACVLC,
    S_HANDOFF
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_block_num;
  logic [15:0] r_slices;
  logic [31:0] r_ac_len;
  logic [15:0] r_slice_index;
  logic        r_slice_start;
  logic        r_dct_active;
  logic        r_dc_active;
  logic        r_ac_active;
  logic        r_slice_valid;
  logic        r_frame_done;
  logic        r_busy;
  logic        r_cfg_error;

  state_t      w_next;
  logic        w_idle;
  logic        w_accept;
  logic        w_empty_frame;
  logic        w_bad_cfg;
  logic        w_handshake;
  logic        w_last_slice;
  logic        w_in_phase;
  logic [31:0] w_dct_len;
  logic [31:0] w_ac_len_in;

  // 63*n + tail, computed as (n<<6)-n so it wraps exactly like the 32-bit datapath
  assign w_ac_len_in = (block_num_in << 6) - block_num_in + 32'(AC_TAIL);
  assign w_dct_len   = 32'(DCT_TIME) + r_block_num;

  always_comb begin
    w_idle        = (r_state == S_IDLE);
    w_bad_cfg     = w_idle && frame_start && !abort && (block_num_in == '0);
    w_empty_frame = w_idle && frame_start && !abort && (block_num_in != '0) &&
                    (slices_per_frame == '0);
    w_accept      = w_idle && frame_start && !abort && (block_num_in != '0) &&
                    (slices_per_frame != '0);
    w_handshake   = (r_state == S_HANDOFF) && pack_ready;
    w_last_slice  = (r_slice_index == (r_slices - 16'd1));
    w_in_phase    = (r_state == S_DCT) || (r_state == S_DCVLC) || (r_state == S_ACVLC);

    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_START;
      S_START:   w_next = S_DCT;
      S_DCT:     if (r_cnt == w_dct_len - 32'd1) w_next = S_DCVLC;
      S_DCVLC:   if (r_cnt == 32'(DC_VLC_TIME) - 32'd1) w_next = S_ACVLC;
      S_ACVLC:   if (r_cnt == r_ac_len - 32'd1) w_next = S_HANDOFF;
      S_HANDOFF: if (w_handshake) w_next = w_last_slice ? S_IDLE : S_START;
      default:   w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_block_num   <= '0;
      r_slices      <= '0;
      r_ac_len      <= '0;
      r_slice_index <= '0;
      r_slice_start <= 1'b0;
      r_dct_active  <= 1'b0;
      r_dc_active   <= 1'b0;
      r_ac_active   <= 1'b0;
      r_slice_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_cfg_error   <= 1'b0;
    end else begin
      r_state <= w_next;

      // Counter runs only while staying inside one phase; any transition clears it
      if (w_in_phase && (w_next == r_state)) r_cnt <= r_cnt + 32'd1;
      else                                   r_cnt <= '0;

      if (w_accept) begin
        r_block_num <= block_num_in;
        r_slices    <= slices_per_frame;
        r_ac_len    <= w_ac_len_in;
      end

      if (abort || w_accept)             r_slice_index <= '0;
      else if (w_handshake)              r_slice_index <= w_last_slice ? '0 : r_slice_index + 16'd1;

      // Flags follow the next state so they rise in the cycle the state is entered
      r_slice_start <= (w_next == S_START);
      r_dct_active  <= (w_next == S_DCT);
      r_dc_active   <= (w_next == S_DCVLC);
      r_ac_active   <= (w_next == S_ACVLC);
      r_slice_valid <= (w_next == S_HANDOFF);
      r_busy        <= (w_next != S_IDLE);
      r_frame_done  <= !abort && ((w_handshake && w_last_slice) || w_empty_frame);
      r_cfg_error   <= w_bad_cfg;
    end
  end

  assign block_num   = r_block_num;
  assign slice_start = r_slice_start;
  assign slice_index = r_slice_index;
  assign dct_active  = r_dct_active;
  assign dc_active   = r_dc_active;
  assign ac_active   = r_ac_active;
  assign slice_valid = r_slice_valid;
  assign frame_done  = r_frame_done;
  assign busy        = r_busy;
  assign cfg_error   = r_cfg_error;

endmodule

// File: tb/tb_slice_scheduler.sv
module tb_slice_scheduler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] slices_per_frame = '0;
  logic [31:0] block_num_in = '0;
  logic        abort = 1'b0;
  logic        pack_ready = 1'b0;
  logic [31:0] block_num;
  logic        slice_start;
  logic [15:0] slice_index;
  logic        dct_active, dc_active, ac_active, slice_valid;
  logic        frame_done, busy, cfg_error;

  slice_scheduler #(.DCT_TIME(12), .DC_VLC_TIME(44), .AC_TAIL(6)) dut (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
    .slices_per_frame(slices_per_frame), .block_num_in(block_num_in),
    .abort(abort), .pack_ready(pack_ready), .block_num(block_num),
    .slice_start(slice_start), .slice_index(slice_index),
    .dct_active(dct_active), .dc_active(dc_active), .ac_active(ac_active),
    .slice_valid(slice_valid), .frame_done(frame_done), .busy(busy),
    .cfg_error(cfg_error)
  );

  always #5 clock = ~clock;

  // Reference model: a slice is a timeline of offsets t since its start pulse.
  // t=0 start, 1..D DCT, next 44 DC-VLC, next A AC-VLC, then t=L handoff (held).
  logic        m_act = 1'b0;
  logic [15:0] m_s = '0;
  logic [31:0] m_bn = '0;
  logic [15:0] m_slice = '0;
  longint      m_t = 0;
  logic        m_done = 1'b0;
  logic        m_cfg = 1'b0;

  function automatic longint dlen(input logic [31:0] bn);
    return 64'(32'd12 + bn);
  endfunction
  function automatic longint alen(input logic [31:0] bn);
    logic [31:0] a;
    a = bn * 32'd63 + 32'd6;
    return 64'(a);
  endfunction
  function automatic longint hoff(input logic [31:0] bn);
    return 1 + dlen(bn) + 44 + alen(bn);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_act <= 1'b0; m_s <= '0; m_bn <= '0; m_slice <= '0; m_t <= 0;
      m_done <= 1'b0; m_cfg <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_cfg  <= 1'b0;
      if (!m_act) begin
        if (frame_start && !abort) begin
          if (block_num_in == 0) m_cfg <= 1'b1;
          else if (slices_per_frame == 0) m_done <= 1'b1;
          else begin
            m_act <= 1'b1; m_s <= slices_per_frame; m_bn <= block_num_in;
            m_slice <= '0; m_t <= 0;
          end
        end
      end else if (abort) begin
        m_act <= 1'b0; m_slice <= '0;
      end else if (m_t == hoff(m_bn)) begin
        if (pack_ready) begin
          if (32'(m_slice) + 1 == 32'(m_s)) begin
            m_act <= 1'b0; m_slice <= '0; m_done <= 1'b1;
          end else begin
            m_slice <= m_slice + 16'd1; m_t <= 0;
          end
        end
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_start = 0, n_dct = 0, n_dc = 0, n_ac = 0, n_valid = 0, n_done = 0, n_cfg = 0;
  int start_cyc[$];
  int done_cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [55:0] a, e;
    longint d, l;
    d = dlen(m_bn);
    l = hoff(m_bn);
    a = {block_num, slice_index, slice_start, dct_active, dc_active, ac_active,
         slice_valid, frame_done, busy, cfg_error};
    e = {m_bn, m_slice, m_act && m_t == 0, m_act && m_t >= 1 && m_t <= d,
         m_act && m_t > d && m_t <= d + 44, m_act && m_t > d + 44 && m_t < l,
         m_act && m_t == l, m_done, m_act, m_cfg};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL outputs cycle %0d: got %h expected %h", cyc, a, e);
    end
    if (slice_start) begin n_start++; start_cyc.push_back(cyc); end
    if (dct_active) n_dct++;
    if (dc_active) n_dc++;
    if (ac_active) n_ac++;
    if (slice_valid) n_valid++;
    if (frame_done) begin n_done++; done_cyc = cyc; end
    if (cfg_error) n_cfg++;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clock);
    compare_all();
    @(posedge clock);
    #2;
  endtask

  task automatic start_frame(input int s, input int bn);
    frame_start = 1'b1;
    slices_per_frame = 16'(s);
    block_num_in = 32'(bn);
    tick();
    frame_start = 1'b0;
  endtask

  // 0: slice_valid, 1: dc_active, 2: ac_active in slice 1
  task automatic wait_sig(input int which, input int maxc, input string nm);
    bit hit;
    hit = 0;
    for (int k = 0; k < maxc; k++) begin
      case (which)
        0: hit = slice_valid;
        1: hit = dc_active;
        default: hit = ac_active && slice_index == 16'd1;
      endcase
      if (hit) break;
      tick();
    end
    if (!hit) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int k;
    for (k = 0; k < maxc; k++) begin
      if (!busy) break;
      tick();
    end
    if (k == maxc) chk({nm, "_timeout"}, 1, 0);
    tick();
  endtask

  int b_start, b_dct, b_dc, b_ac, b_valid, b_done, b_cfg, q0;

  task automatic snap();
    b_start = n_start; b_dct = n_dct; b_dc = n_dc; b_ac = n_ac;
    b_valid = n_valid; b_done = n_done; b_cfg = n_cfg; q0 = start_cyc.size();
  endtask

  initial begin
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_block_num", block_num, 0);
    pack_ready = 1'b1;

    // single slice, 4 blocks
    snap();
    start_frame(1, 4);
    wait_idle(2000, "frame1");
    chk("f1_dct_cycles", n_dct - b_dct, 16);
    chk("f1_dc_cycles", n_dc - b_dc, 44);
    chk("f1_ac_cycles", n_ac - b_ac, 258);
    chk("f1_valid_cycles", n_valid - b_valid, 1);
    chk("f1_done_count", n_done - b_done, 1);
    chk("f1_done_latency", done_cyc - start_cyc[q0], 320);
    chk("f1_busy_after", busy, 0);

    // three slices, 1 block
    snap();
    start_frame(3, 1);
    wait_idle(2000, "frame2");
    chk("f2_starts", n_start - b_start, 3);
    chk("f2_gap01", start_cyc[q0 + 1] - start_cyc[q0], 128);
    chk("f2_gap12", start_cyc[q0 + 2] - start_cyc[q0 + 1], 128);
    chk("f2_done_count", n_done - b_done, 1);

    // backpressure in the first handoff
    snap();
    pack_ready = 1'b0;
    start_frame(2, 2);
    wait_sig(0, 1000, "f3_valid");
    repeat (10) tick();
    chk("f3_index_held", slice_index, 0);
    pack_ready = 1'b1;
    wait_idle(2000, "frame3");
    chk("f3_valid_cycles", n_valid - b_valid, 12);
    chk("f3_gap", start_cyc[q0 + 1] - start_cyc[q0], 202);
    chk("f3_done_count", n_done - b_done, 1);

    // rejected and empty commands
    snap();
    start_frame(1, 0);
    tick();
    chk("cfg_pulse", n_cfg - b_cfg, 1);
    chk("cfg_busy", busy, 0);
    start_frame(0, 3);
    tick();
    chk("empty_done", n_done - b_done, 1);
    chk("empty_starts", n_start - b_start, 0);

    // abort during AC-VLC of slice 1
    snap();
    start_frame(4, 1);
    wait_sig(2, 1000, "abort_wait");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ac", ac_active, 0);
    chk("abort_index", slice_index, 0);
    repeat (3) tick();
    chk("abort_no_done", n_done - b_done, 0);
    start_frame(2, 1);
    chk("restart_start", slice_start, 1);
    chk("restart_index", slice_index, 0);
    wait_idle(1000, "restart");

    // frame_start while busy, then asynchronous reset mid DC-VLC
    start_frame(3, 2);
    wait_sig(1, 1000, "dc_wait");
    frame_start = 1'b1; slices_per_frame = 16'd1; block_num_in = 32'd7;
    tick();
    frame_start = 1'b0;
    chk("busy_ignore_bn", block_num, 2);
    chk("busy_ignore_dc", dc_active, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_dc", dc_active, 0);
    chk("async_block_num", block_num, 0);
    tick();
    reset_n = 1'b1;
    snap();
    repeat (5) tick();
    chk("release_no_start", n_start - b_start, 0);

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      frame_start = ($urandom_range(0, 7) == 0);
      slices_per_frame = 16'($urandom_range(0, 4));
      block_num_in = 32'($urandom_range(0, 5));
      pack_ready = ($urandom_range(0, 2) != 0);
      abort = ($urandom_range(0, 699) == 0);
      tick();
    end
    abort = 1'b0;
    frame_start = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slice_scheduler.md
Name: slice_scheduler

Overview:
- Frame-level controller for the ProRes slice pipeline.
- Accepts a frame command (slice count, blocks per slice) and issues one slice_start per slice.
- Times each slice through the DCT, DC-VLC and AC-VLC phases, then hands the finished slice to the bitstream packer with a valid/ready handshake.
- Sits above the per-slice sequencer; drives its slice_start and block_num and gates the VLC stages.

Parameters:
- DCT_TIME, 12, fixed DCT latency in cycles, added to block_num
- DC_VLC_TIME, 44, DC-VLC phase length in cycles
- AC_TAIL, 6, extra AC-VLC cycles beyond 63*block_num

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- frame_start  input  1  one-cycle command pulse; sampled only in IDLE
- slices_per_frame  input  16  slice count; latched on accepted frame_start
- block_num_in  input  32  blocks per slice; latched on accepted frame_start
- abort  input  1  synchronous abort; highest priority after reset
- pack_ready  input  1  packer can accept a slice
- block_num  output  32  latched block count, driven to the sequencer
- slice_start  output  1  one-cycle pulse per slice
- slice_index  output  16  index of the current slice, 0-based
- dct_active  output  1  high during the DCT phase
- dc_active  output  1  high during the DC-VLC phase
- ac_active  output  1  high during the AC-VLC phase
- slice_valid  output  1  finished slice offered to the packer
- frame_done  output  1  one-cycle pulse after the last slice handshake
- busy  output  1  high whenever state is not IDLE
- cfg_error  output  1  one-cycle pulse on a rejected frame command

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE.
  - All outputs 0; block_num=0; slice_index=0.
  - Internal phase counter and slice counter are 0.
- States: IDLE, START, DCT, DCVLC, ACVLC, HANDOFF.
- IDLE:
  - frame_start=1 and block_num_in!=0 and slices_per_frame!=0:
    - latch both inputs; slice_index=0
    - precompute ac_len = (block_num<<6) - block_num + AC_TAIL, 32-bit, wraps modulo 2^32
    - go to START
  - frame_start=1 with block_num_in==0: cfg_error pulse, stay IDLE.
  - frame_start=1 with slices_per_frame==0: frame_done pulse next cycle, no slice issued, stay IDLE.
  - frame_start while not IDLE is ignored.
- START (1 cycle): slice_start=1; phase counter cleared; next state DCT.
- Phase states:
  - DCT lasts DCT_TIME+block_num cycles with dct_active=1.
  - DCVLC lasts DC_VLC_TIME cycles with dc_active=1.
  - ACVLC lasts ac_len cycles with ac_active=1.
  - The phase counter counts 0..len-1 in each phase and clears on every phase change.
  - Exactly one phase flag is high in these states.
- HANDOFF:
  - slice_valid=1, held stable until slice_valid&&pack_ready.
  - On the handshake cycle:
    - last slice (slice_index==slices_per_frame-1): frame_done=1 in the next cycle, state IDLE, slice_index=0.
    - otherwise: slice_index+1, state START.
  - Back-to-back slices: with pack_ready held high, HANDOFF lasts 1 cycle.
- Per-slice cycle count, with pack_ready high: 1 + (DCT_TIME+block_num) + DC_VLC_TIME + ac_len + 1.
  - block_num=4 gives 1+16+44+258+1 = 320 cycles.
- Flags (slice_start, dct/dc/ac_active, slice_valid, busy) are registered from the next-state decode, so each asserts in the same cycle the state is entered. No combinational input-to-output paths.
- abort=1 in any state: next cycle state=IDLE, all flags 0, slice_index=0, no frame_done. abort in IDLE has no effect. abort and frame_start in the same cycle: abort wins and the frame is not accepted.
- Reset mid-slice: immediate return to reset values; no pulse is emitted on release.
- block_num and slices_per_frame are held constant for the whole frame; input changes mid-frame are ignored.

Test Plan:
- Reset, then frame_start with slices=1, block_num_in=4, pack_ready=1 -> slice_start at cycle T, dct_active for 16 cycles, dc_active 44, ac_active 258, slice_valid 1 cycle, frame_done at T+320, busy 0 after.
- slices=3, block_num_in=1, pack_ready=1 -> three slice_start pulses exactly 1+13+44+69+1=128 cycles apart; slice_index 0,1,2; single frame_done.
- slices=2, block_num_in=2, pack_ready low for 10 cycles in HANDOFF -> slice_valid held 11 cycles, slice_index unchanged until handshake, second slice_start the cycle after handshake.
- frame_start with block_num_in=0 -> cfg_error pulse, busy stays 0. With slices=0 -> frame_done pulse, no slice_start.
- abort asserted during ACVLC of slice 1 of 4 -> all flags 0 the next cycle, IDLE, no frame_done. A new frame_start then restarts from slice_index 0.
- reset_n pulsed low mid-DCVLC, and frame_start sent while busy -> outputs clear asynchronously; the mid-frame frame_start causes no state change and no restart.
